// File: rtl/plic_target_context.sv
// plic_target_context
// Per-hart claim/complete controller on the target side of the PLIC.
// It turns the core's notification into the hart's external-interrupt line,
// runs the claim handshake with the core when software reads the claim
// register, and holds the claimed ID in service until software writes the
// matching completion. The completion is then reported to the gateways as a
// one-cycle ready pulse.
//
// Optional feature, controlled by the macro PLIC_CLAIM_TIMEOUT_EN:
//   defined   - an ID left in service for TIMEOUT_CYCLES cycles is completed
//               automatically, and timeout_o pulses together with ready.
//   undefined - SERVICE waits indefinitely and timeout_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   interrupt_target_notification_i        core has a pending interrupt
//   interrupt_target_id_i                  highest-priority ID from core
//   interrupt_target_claim_o               32'h1 while claiming, else 0
//   interrupt_target_ready_o               one-cycle completion pulse
//   interrupt_target_priority_threshold_o  threshold register to core
//   meip_o                                 machine external interrupt pending
//   claim_read_i / claim_rdata_o / claim_rvalid_o   claim register read
//   complete_write_i / complete_wdata_i    complete register write
//   threshold_write_i / threshold_wdata_i  threshold register write
//   timeout_o                              service-timeout pulse
//
// State table:
//   IDLE     | nothing pending, nothing in service
//   PENDING  | core is notifying; meip asserted, waiting for software read
//   CLAIM    | claim request to core; ID sampled at the end of the cycle
//   RESPOND  | claim read data returned to software
//   SERVICE  | ID in service, waiting for matching completion
//   COMPLETE | ready pulse to gateways, in-service ID cleared

module plic_target_context #(
    parameter int N_INTERRUPT_SOURCES = 32,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        interrupt_target_notification_i,
    input  logic [31:0] interrupt_target_id_i,
    output logic [31:0] interrupt_target_claim_o,
    output logic        interrupt_target_ready_o,
    output logic [31:0] interrupt_target_priority_threshold_o,
    output logic        meip_o,
    input  logic        claim_read_i,
    output logic [31:0] claim_rdata_o,
    output logic        claim_rvalid_o,
    input  logic        complete_write_i,
    input  logic [31:0] complete_wdata_i,
    input  logic        threshold_write_i,
    input  logic [31:0] threshold_wdata_i,
    output logic        timeout_o
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PENDING  = 3'd1;
    localparam logic [2:0] ST_CLAIM    = 3'd2;
    localparam logic [2:0] ST_RESPOND  = 3'd3;
    localparam logic [2:0] ST_SERVICE  = 3'd4;
    localparam logic [2:0] ST_COMPLETE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] id_q;            // claimed ID; 0 when the claim was invalid
    logic [31:0] threshold_q;
    logic        quick_rvalid_q;  // zero-data response outside the claim path
    logic        id_valid;
    logic        complete_match;
    logic        read_accept;
    logic        timeout_hit;

    assign id_valid = (interrupt_target_id_i != 32'd0) &&
                      (interrupt_target_id_i <= 32'(N_INTERRUPT_SOURCES));

    assign complete_match = complete_write_i && (complete_wdata_i == id_q);

    // A read arriving while a zero-data response is being returned is dropped.
    assign read_accept = claim_read_i && !quick_rvalid_q;

`ifdef PLIC_CLAIM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] svc_cnt_q;
    logic          timeout_q;

    // Expires in the cycle the count would reach TIMEOUT_CYCLES, i.e. after
    // exactly TIMEOUT_CYCLES cycles spent in SERVICE.
    assign timeout_hit = (state_q == ST_SERVICE) &&
                         (svc_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            svc_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_SERVICE) begin
                svc_cnt_q <= svc_cnt_q + 1'b1;
            end else begin
                svc_cnt_q <= '0;
            end
            // A matching completion in the expiry cycle is a normal completion.
            timeout_q <= timeout_hit && !complete_match;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT_CYCLES has no effect without the timeout feature; this folds to 0.
    assign timeout_o   = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (interrupt_target_notification_i) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                // Read wins over a simultaneous notification drop.
                if (read_accept) begin
                    state_d = ST_CLAIM;
                end else if (!interrupt_target_notification_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLAIM: begin
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                state_d = (id_q != 32'd0) ? ST_SERVICE : ST_IDLE;
            end
            ST_SERVICE: begin
                if (complete_match || timeout_hit) state_d = ST_COMPLETE;
            end
            ST_COMPLETE: begin
                state_d = interrupt_target_notification_i ? ST_PENDING : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            id_q           <= 32'd0;
            threshold_q    <= 32'd0;
            quick_rvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_CLAIM) begin
                id_q <= id_valid ? interrupt_target_id_i : 32'd0;
            end else if (state_q == ST_COMPLETE) begin
                id_q <= 32'd0;
            end

            if (threshold_write_i) begin
                threshold_q <= threshold_wdata_i;
            end

            // PENDING reads go through CLAIM/RESPOND; reads during CLAIM find
            // a response already pending and are dropped.
            quick_rvalid_q <= read_accept &&
                              (state_q != ST_PENDING) &&
                              (state_q != ST_CLAIM);
        end
    end

    assign interrupt_target_claim_o              = (state_q == ST_CLAIM) ? 32'h1 : 32'h0;
    assign interrupt_target_ready_o              = (state_q == ST_COMPLETE);
    assign interrupt_target_priority_threshold_o = threshold_q;
    assign meip_o                                = (state_q == ST_PENDING);
    assign claim_rvalid_o                        = (state_q == ST_RESPOND) || quick_rvalid_q;
    assign claim_rdata_o                         = (state_q == ST_RESPOND) ? id_q : 32'd0;

endmodule

// File: tb/tb_plic_target_context.sv
module tb_plic_target_context;

    localparam int N = 32;
    localparam int T = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        interrupt_target_notification_i;
    logic [31:0] interrupt_target_id_i;
    logic [31:0] interrupt_target_claim_o;
    logic        interrupt_target_ready_o;
    logic [31:0] interrupt_target_priority_threshold_o;
    logic        meip_o;
    logic        claim_read_i;
    logic [31:0] claim_rdata_o;
    logic        claim_rvalid_o;
    logic        complete_write_i;
    logic [31:0] complete_wdata_i;
    logic        threshold_write_i;
    logic [31:0] threshold_wdata_i;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    plic_target_context #(
        .N_INTERRUPT_SOURCES(N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .interrupt_target_notification_i(interrupt_target_notification_i),
        .interrupt_target_id_i(interrupt_target_id_i),
        .interrupt_target_claim_o(interrupt_target_claim_o),
        .interrupt_target_ready_o(interrupt_target_ready_o),
        .interrupt_target_priority_threshold_o(interrupt_target_priority_threshold_o),
        .meip_o(meip_o),
        .claim_read_i(claim_read_i),
        .claim_rdata_o(claim_rdata_o),
        .claim_rvalid_o(claim_rvalid_o),
        .complete_write_i(complete_write_i),
        .complete_wdata_i(complete_wdata_i),
        .threshold_write_i(threshold_write_i),
        .threshold_wdata_i(threshold_wdata_i),
        .timeout_o(timeout_o)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference rule: the core's ID is returned only if it names a real source.
    function automatic logic [31:0] model_rdata(input logic [31:0] id);
        return (id >= 32'd1 && id <= 32'(N)) ? id : 32'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk32({tag, "_claim"}, interrupt_target_claim_o, 32'd0);
        chk1({tag, "_ready"}, interrupt_target_ready_o, 1'b0);
        chk32({tag, "_thr"}, interrupt_target_priority_threshold_o, 32'd0);
        chk1({tag, "_meip"}, meip_o, 1'b0);
        chk1({tag, "_rvalid"}, claim_rvalid_o, 1'b0);
        chk32({tag, "_rdata"}, claim_rdata_o, 32'd0);
        chk1({tag, "_timeout"}, timeout_o, 1'b0);
    endtask

    // Notification -> meip -> read -> CLAIM -> RESPOND. Returns the ID that
    // the model expects to be in service (0 = none).
    task automatic do_claim(input logic [31:0] id, output logic [31:0] svc);
        svc = model_rdata(id);
        interrupt_target_notification_i = 1'b1;
        interrupt_target_id_i = id;
        chk1("meip_before_sample", meip_o, 1'b0);
        tick();
        chk1("meip_pending", meip_o, 1'b1);
        chk32("claim_pending", interrupt_target_claim_o, 32'd0);
        claim_read_i = 1'b1;
        tick();
        claim_read_i = 1'b0;
        chk32("claim_pulse", interrupt_target_claim_o, 32'h1);
        chk1("meip_in_claim", meip_o, 1'b0);
        chk1("rvalid_in_claim", claim_rvalid_o, 1'b0);
        tick();
        interrupt_target_notification_i = 1'b0;
        chk1("rvalid_respond", claim_rvalid_o, 1'b1);
        chk32("rdata_respond", claim_rdata_o, svc);
        chk32("claim_after", interrupt_target_claim_o, 32'd0);
        tick();
        chk1("rvalid_after_respond", claim_rvalid_o, 1'b0);
        chk1("meip_after_respond", meip_o, 1'b0);
        chk1("ready_after_respond", interrupt_target_ready_o, 1'b0);
    endtask

    task automatic do_complete(input logic [31:0] id);
        complete_write_i = 1'b1;
        complete_wdata_i = id;
        tick();
        complete_write_i = 1'b0;
        chk1("ready_pulse", interrupt_target_ready_o, 1'b1);
        chk1("timeout_on_complete", timeout_o, 1'b0);
        tick();
        chk1("ready_single", interrupt_target_ready_o, 1'b0);
        chk1("meip_back_idle", meip_o, 1'b0);
    endtask

    initial begin
        logic [31:0] svc;
        logic [31:0] id;
        logic [31:0] bad;
        logic [31:0] thr;
        int          pulses;

        rst_ni = 1'b0;
        interrupt_target_notification_i = 1'b0;
        interrupt_target_id_i = 32'd0;
        claim_read_i = 1'b0;
        complete_write_i = 1'b0;
        complete_wdata_i = 32'd0;
        threshold_write_i = 1'b0;
        threshold_wdata_i = 32'd0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Claim ID 5 and complete it.
        do_claim(32'd5, svc);
        do_complete(svc);

        // Mismatched completion is ignored, matching one is taken.
        do_claim(32'd5, svc);
        complete_write_i = 1'b1;
        complete_wdata_i = 32'd7;
        tick();
        complete_write_i = 1'b0;
        chk1("mismatch_no_ready", interrupt_target_ready_o, 1'b0);
        do_complete(32'd5);

        // Notification for 2 cycles with no read.
        interrupt_target_notification_i = 1'b1;
        interrupt_target_id_i = 32'd9;
        tick();
        chk1("pulse_meip_1", meip_o, 1'b1);
        chk32("pulse_claim_1", interrupt_target_claim_o, 32'd0);
        tick();
        interrupt_target_notification_i = 1'b0;
        chk1("pulse_meip_2", meip_o, 1'b1);
        chk32("pulse_claim_2", interrupt_target_claim_o, 32'd0);
        tick();
        chk1("pulse_meip_drop", meip_o, 1'b0);
        chk32("pulse_claim_3", interrupt_target_claim_o, 32'd0);

        // Invalid IDs at both boundaries.
        do_claim(32'd0, svc);
        chk32("id0_no_service", svc, 32'd0);
        do_claim(32'(N + 1), svc);
        chk32("idN1_no_service", svc, 32'd0);
        tick();
        chk1("invalid_no_ready", interrupt_target_ready_o, 1'b0);
        do_claim(32'(N), svc);
        do_complete(32'(N));

        // Read in IDLE returns 0 after one cycle; completion in IDLE is ignored.
        claim_read_i = 1'b1;
        complete_write_i = 1'b1;
        complete_wdata_i = 32'd0;
        tick();
        claim_read_i = 1'b0;
        complete_write_i = 1'b0;
        chk1("idle_rvalid", claim_rvalid_o, 1'b1);
        chk32("idle_rdata", claim_rdata_o, 32'd0);
        chk1("idle_complete_ignored", interrupt_target_ready_o, 1'b0);
        tick();
        chk1("idle_rvalid_single", claim_rvalid_o, 1'b0);

        // Read and notification drop in the same PENDING cycle: read wins.
        interrupt_target_notification_i = 1'b1;
        interrupt_target_id_i = 32'd3;
        tick();
        interrupt_target_notification_i = 1'b0;
        claim_read_i = 1'b1;
        tick();
        claim_read_i = 1'b0;
        chk32("race_claim", interrupt_target_claim_o, 32'h1);
        tick();
        chk32("race_rdata", claim_rdata_o, 32'd3);
        tick();
        do_complete(32'd3);

        // Randomized claim/service rounds against the model.
        for (int i = 0; i < 16; i++) begin
            id = 32'($urandom_range(0, N + 2));
            do_claim(id, svc);
            thr = $urandom;
            threshold_write_i = 1'b1;
            threshold_wdata_i = thr;
            tick();
            threshold_write_i = 1'b0;
            chk32("rand_threshold", interrupt_target_priority_threshold_o, thr);
            if (svc != 32'd0) begin
                bad = svc ^ 32'($urandom_range(1, 63));
                complete_write_i = 1'b1;
                complete_wdata_i = bad;
                tick();
                complete_write_i = 1'b0;
                chk1("rand_mismatch", interrupt_target_ready_o, 1'b0);
                if ($urandom_range(0, 1) == 1) begin
                    claim_read_i = 1'b1;
                    complete_write_i = 1'b1;
                    complete_wdata_i = svc;
                    tick();
                    claim_read_i = 1'b0;
                    complete_write_i = 1'b0;
                    chk1("rand_both_ready", interrupt_target_ready_o, 1'b1);
                    chk1("rand_both_rvalid", claim_rvalid_o, 1'b1);
                    chk32("rand_both_rdata", claim_rdata_o, 32'd0);
                    tick();
                    chk1("rand_both_ready_off", interrupt_target_ready_o, 1'b0);
                    chk1("rand_both_rvalid_off", claim_rvalid_o, 1'b0);
                end else begin
                    claim_read_i = 1'b1;
                    tick();
                    claim_read_i = 1'b0;
                    chk1("rand_svc_rvalid", claim_rvalid_o, 1'b1);
                    chk32("rand_svc_rdata", claim_rdata_o, 32'd0);
                    chk1("rand_svc_meip", meip_o, 1'b0);
                    do_complete(svc);
                end
            end else begin
                tick();
                chk1("rand_invalid_ready", interrupt_target_ready_o, 1'b0);
                chk1("rand_invalid_meip", meip_o, 1'b0);
            end
        end

        // Threshold write in SERVICE, then reset mid-service.
        do_claim(32'd5, svc);
        threshold_write_i = 1'b1;
        threshold_wdata_i = 32'h3;
        tick();
        threshold_write_i = 1'b0;
        chk32("svc_threshold", interrupt_target_priority_threshold_o, 32'h3);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (interrupt_target_ready_o === 1'b1) pulses++;
        end
        chk32("mid_reset_no_ready", 32'(pulses), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk_all_zero("after_mid_reset");

        // Claim ID 2 and never complete.
        do_claim(32'd2, svc);
`ifdef PLIC_CLAIM_TIMEOUT_EN
        for (int i = 1; i < T; i++) begin
            tick();
            chk1("to_wait_ready", interrupt_target_ready_o, 1'b0);
            chk1("to_wait_timeout", timeout_o, 1'b0);
        end
        tick();
        chk1("to_ready", interrupt_target_ready_o, 1'b1);
        chk1("to_timeout", timeout_o, 1'b1);
        tick();
        chk1("to_ready_off", interrupt_target_ready_o, 1'b0);
        chk1("to_timeout_off", timeout_o, 1'b0);
`else
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (interrupt_target_ready_o === 1'b1 || timeout_o === 1'b1) pulses++;
        end
        chk32("no_timeout_pulses", 32'(pulses), 32'd0);
        do_complete(32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
